// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - UART transmit serializer with one-entry holding register
// Frames are start / data LSB-first / optional parity / stop; every line change is on a baud_tick.
module uart_tx_serializer #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 baud_tick,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 serial_out,
    output logic                 tx_busy
);

    localparam int            CW        = $clog2(DATA_BITS);
    localparam logic [CW-1:0] BIT_LAST  = CW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = (STOP_BITS == 2);
    localparam logic          ODD       = (PARITY_ODD != 0);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]           state_q,    state_d;
    logic [DATA_BITS-1:0] hold_q,     hold_d;
    logic                 hold_full_q, hold_full_d;
    logic [DATA_BITS-1:0] shift_q,    shift_d;
    logic [CW-1:0]        bit_cnt_q,  bit_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 parity_q,   parity_d;
    logic                 serial_q,   serial_d;

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        stop_cnt_d  = stop_cnt_q;
        parity_d    = parity_q;
        serial_d    = serial_q;

        if (baud_tick) begin
            case (state_q)
                S_IDLE: begin
                    serial_d = 1'b1;
                    if (hold_full_q) begin
                        shift_d     = hold_q;
                        hold_full_d = 1'b0;
                        serial_d    = 1'b0;
                        state_d     = S_START;
                    end
                end
                S_START: begin
                    serial_d  = shift_q[0];
                    shift_d   = shift_q >> 1;
                    parity_d  = shift_q[0];
                    bit_cnt_d = '0;
                    state_d   = S_DATA;
                end
                S_DATA: begin
                    if (bit_cnt_q == BIT_LAST) begin
                        if (PARITY_EN != 0) begin
                            serial_d = parity_q ^ ODD;
                            state_d  = S_PARITY;
                        end else begin
                            serial_d   = 1'b1;
                            stop_cnt_d = 1'b0;
                            state_d    = S_STOP;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + CW'(1);
                        serial_d  = shift_q[0];
                        shift_d   = shift_q >> 1;
                        parity_d  = parity_q ^ shift_q[0];
                    end
                end
                S_PARITY: begin
                    serial_d   = 1'b1;
                    stop_cnt_d = 1'b0;
                    state_d    = S_STOP;
                end
                S_STOP: begin
                    if (stop_cnt_q == STOP_LAST) begin
                        // A waiting byte starts its frame on the same tick, so no idle gap.
                        if (hold_full_q) begin
                            shift_d     = hold_q;
                            hold_full_d = 1'b0;
                            serial_d    = 1'b0;
                            state_d     = S_START;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
                default: begin
                    serial_d = 1'b1;
                    state_d  = S_IDLE;
                end
            endcase
        end

        // Applied last so a byte accepted while the hold drains to the shifter keeps hold_full set.
        if (tx_valid && !hold_full_q) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            stop_cnt_q  <= 1'b0;
            parity_q    <= 1'b0;
            serial_q    <= 1'b1;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            stop_cnt_q  <= stop_cnt_d;
            parity_q    <= parity_d;
            serial_q    <= serial_d;
        end
    end

    assign tx_ready   = ~hold_full_q;
    assign serial_out = serial_q;
    assign tx_busy    = (state_q != S_IDLE) | hold_full_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb/tb_uart_tx_serializer.sv - directed bench for uart_tx_serializer
// Index 0 = 8N1, index 1 = 8E1, index 2 = 8O2; all share clk, reset and the byte handshake inputs.
module tb_uart_tx_serializer;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       baud_tick = 1'b0;
    logic       tx_valid  = 1'b0;
    logic [7:0] tx_data   = 8'h00;
    logic [2:0] line, ready, busy;
    int         vectors     = 0;
    int         miscompares = 0;
    int         tick_cnt    = 0;

    always #5 clk = ~clk;

    always @(negedge clk) begin
        tick_cnt  = (tick_cnt == 7) ? 0 : tick_cnt + 1;
        baud_tick = (tick_cnt == 7);
    end

    uart_tx_serializer #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(ready[0]), .serial_out(line[0]), .tx_busy(busy[0]));

    uart_tx_serializer #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_pe (
        .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(ready[1]), .serial_out(line[1]), .tx_busy(busy[1]));

    uart_tx_serializer #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u_po (
        .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(ready[2]), .serial_out(line[2]), .tx_busy(busy[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bit 0 is the start bit; everything above the frame reads as idle-high line.
    function automatic logic [31:0] frame(input logic [7:0] d, input bit par_en, input logic p);
        logic [31:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = d;
        if (par_en) f[9] = p;
        return f;
    endfunction

    task automatic accept(input logic [7:0] d, input bit hold);
        tx_data  = d;
        tx_valid = 1'b1;
        for (int i = 0; i < 40 && ready[0] !== 1'b1; i++) @(negedge clk);
        chk("accept_ready", {31'd0, ready[0]}, 32'd1);
        @(negedge clk);
        chk("accept_taken", {31'd0, ready[0]}, 32'd0);
        if (!hold) tx_valid = 1'b0;
    endtask

    task automatic wait_start(input string tag);
        int n = 0;
        while (line[0] !== 1'b0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {31'd0, line[0]}, 32'd0);
    endtask

    // Caller is at the negedge with offset 'first' from the start edge; every clk of every bit is checked.
    task automatic check_lines(input string tag, input int first, input int nbits, input logic [2:0] en,
                               input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2);
        for (int i = first; i < nbits * 8; i++) begin
            if (i != first) @(negedge clk);
            if (en[0]) chk(tag, {31'd0, line[0]}, {31'd0, e0[i/8]});
            if (en[1]) chk(tag, {31'd0, line[1]}, {31'd0, e1[i/8]});
            if (en[2]) chk(tag, {31'd0, line[2]}, {31'd0, e2[i/8]});
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset while the clock and baud strobe run, then idle release
        repeat (3) @(negedge clk);
        chk("rst_line",  {29'd0, line},  32'h7);
        chk("rst_ready", {29'd0, ready}, 32'h7);
        chk("rst_busy",  {29'd0, busy},  32'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            chk("idle_line", {29'd0, line}, 32'h7);
            chk("idle_busy", {29'd0, busy}, 32'h0);
        end

        // 2: single 0xA5 on 8N1, line 0,1,0,1,0,0,1,0,1,1
        accept(8'hA5, 1'b0);
        wait_start("a5_start");
        check_lines("a5_bits", 0, 10, 3'b001, 32'hFFFF_FF4A, 32'h0, 32'h0);
        chk("a5_busy_last", {31'd0, busy[0]}, 32'd1);
        @(negedge clk);
        chk("a5_busy_done", {31'd0, busy[0]}, 32'd0);
        chk("a5_line_done", {31'd0, line[0]}, 32'd1);

        // 3: 0x3C then 0xFF with valid held, no gap between frames
        accept(8'h3C, 1'b1);
        wait_start("b2b_start");
        chk("b2b_hold_free", {31'd0, ready[0]}, 32'd1);
        tx_data = 8'hFF;
        @(negedge clk);
        chk("b2b_second_acc", {31'd0, ready[0]}, 32'd0);
        chk("b2b_busy", {31'd0, busy[0]}, 32'd1);
        tx_valid = 1'b0;
        check_lines("b2b_bits", 1, 20, 3'b001, {12'hFFF, 1'b1, 8'hFF, 1'b0, 1'b1, 8'h3C, 1'b0}, 32'h0, 32'h0);
        @(negedge clk);
        chk("b2b_busy_done", {31'd0, busy[0]}, 32'd0);

        // 5: holding register full, third byte waits for the shifter to load
        accept(8'h12, 1'b1);
        wait_start("full_start");
        chk("full_hold_free", {31'd0, ready[0]}, 32'd1);
        tx_data = 8'h34;
        @(negedge clk);
        chk("full_second_acc", {31'd0, ready[0]}, 32'd0);
        tx_data = 8'h56;
        for (int i = 2; i < 80; i++) begin
            @(negedge clk);
            chk("full_ready_low", {31'd0, ready[0]}, 32'd0);
        end
        @(negedge clk);
        chk("full_ready_reopen", {31'd0, ready[0]}, 32'd1);
        chk("full_b_start", {31'd0, line[0]}, 32'd0);
        @(negedge clk);
        chk("full_third_acc", {31'd0, ready[0]}, 32'd0);
        tx_valid = 1'b0;
        check_lines("full_b_bits", 1, 10, 3'b001, frame(8'h34, 1'b0, 1'b0), 32'h0, 32'h0);
        @(negedge clk);
        check_lines("full_c_bits", 0, 10, 3'b001, frame(8'h56, 1'b0, 1'b0), 32'h0, 32'h0);
        @(negedge clk);
        chk("full_busy_done", {31'd0, busy[0]}, 32'd0);

        // 6: reset during data bit 3 with a byte waiting in the hold register
        accept(8'h00, 1'b1);
        wait_start("mid_start");
        tx_data = 8'hC3;
        @(negedge clk);
        chk("mid_hold_full", {31'd0, ready[0]}, 32'd0);
        tx_valid = 1'b0;
        repeat (34) @(negedge clk);
        chk("mid_bit3_line", {31'd0, line[0]}, 32'd0);
        chk("mid_bit3_busy", {31'd0, busy[0]}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_line",  {29'd0, line},  32'h7);
        chk("mid_rst_ready", {29'd0, ready}, 32'h7);
        chk("mid_rst_busy",  {29'd0, busy},  32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            chk("mid_post_line", {31'd0, line[0]}, 32'd1);
            chk("mid_post_busy", {31'd0, busy[0]}, 32'd0);
        end
        accept(8'h5A, 1'b0);
        wait_start("clean_start");
        check_lines("clean_bits", 0, 10, 3'b001, frame(8'h5A, 1'b0, 1'b0), 32'h0, 32'h0);
        @(negedge clk);
        chk("clean_busy_done", {31'd0, busy[0]}, 32'd0);
        repeat (40) @(negedge clk);

        // 4: parity and two stop bits; 0xA5 even parity 0 / odd 1, 0x01 even 1 / odd 0
        accept(8'hA5, 1'b0);
        wait_start("par_a5_start");
        check_lines("par_a5_bits", 0, 12, 3'b111, frame(8'hA5, 1'b0, 1'b0),
                    frame(8'hA5, 1'b1, 1'b0), frame(8'hA5, 1'b1, 1'b1));
        chk("par_a5_busy95", {29'd0, busy}, 32'h4);
        @(negedge clk);
        chk("par_a5_busy96", {29'd0, busy}, 32'h0);

        accept(8'h01, 1'b0);
        wait_start("par_01_start");
        check_lines("par_01_bits", 0, 12, 3'b111, frame(8'h01, 1'b0, 1'b0),
                    frame(8'h01, 1'b1, 1'b1), frame(8'h01, 1'b1, 1'b0));
        chk("par_01_busy95", {29'd0, busy}, 32'h4);
        @(negedge clk);
        chk("par_01_busy96", {29'd0, busy}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
